// File: rtl/proc_stall_pkg.sv
// Shared definitions for the processor stall controller: FSM state encoding,
// wait-state limits and a pointer-width helper.
package proc_stall_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Largest supported number of fixed wait states per access
    localparam int WAIT_CYCLES_MAX = 15;
    // Width of the wait-state down-counter, sized for WAIT_CYCLES_MAX
    localparam int WAIT_CNT_W      = 4;

    // Width of a channel index; a single channel still needs one bit
    function automatic int ptr_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting channel
// strictly after last_ptr, wrapping from NUM_CH-1 back to 0.
module rr_arbiter
    import proc_stall_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int PTR_W  = ptr_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  last_ptr,
    output logic [NUM_CH-1:0] grant
);

    logic             found_s;
    logic             hit_s;
    logic [PTR_W-1:0] idx_s;

    // Walk the channels upward from last_ptr+1; the first requester wins
    always_comb begin
        grant   = {NUM_CH{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        idx_s   = {PTR_W{1'b0}};
        for (int i = 1; i <= NUM_CH; i++) begin
            idx_s        = PTR_W'((int'(last_ptr) + i) % NUM_CH);
            hit_s        = req[idx_s] & ~found_s;
            grant[idx_s] = hit_s;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/proc_stall_ctrl.sv
// Processor stall controller: arbitrates memory channels round-robin, holds
// the processor clock enable low for the access (fixed wait states plus
// memory busy), then releases it for exactly one DONE cycle.
// Optional macro STALL_PERF_CNT_EN adds a saturating stall-cycle counter
// with the perf_clr / stall_cnt ports.
module proc_stall_ctrl
    import proc_stall_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] grant,
    output logic              proc_ce
`ifdef STALL_PERF_CNT_EN
    ,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    localparam int PTR_W    = ptr_width(NUM_CH);
    localparam int WAIT_EFF = (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES;
    // Counter preload so that WAIT lasts exactly WAIT_EFF cycles (counts down to 0)
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_EFF > 0) ? WAIT_CNT_W'(WAIT_EFF - 1) : {WAIT_CNT_W{1'b0}};

    state_t                  state_r;
    state_t                  next_state_s;
    logic [NUM_CH-1:0]       grant_r;
    logic [NUM_CH-1:0]       next_grant_s;
    logic [NUM_CH-1:0]       arb_grant_s;
    logic [WAIT_CNT_W-1:0]   wait_cnt_r;
    logic [WAIT_CNT_W-1:0]   next_wait_cnt_s;
    logic [PTR_W-1:0]        last_ptr_r;
    logic [PTR_W-1:0]        next_last_ptr_s;
    logic [PTR_W-1:0]        grant_idx_s;
    logic                    hold_busy_s;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_rr_arbiter (
        .req      (req),
        .last_ptr (last_ptr_r),
        .grant    (arb_grant_s)
    );

    // Only the granted channel's busy flag can extend HOLD
    assign hold_busy_s = |(busy & grant_r);

    // Encode the one-hot grant into a channel index for the round-robin pointer
    always_comb begin
        grant_idx_s = {PTR_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            grant_idx_s = grant_idx_s | (grant_r[i] ? PTR_W'(i) : {PTR_W{1'b0}});
        end
    end

    // Next-state, next-grant, wait-counter and pointer update logic
    always_comb begin
        next_state_s    = state_r;
        next_grant_s    = grant_r;
        next_wait_cnt_s = wait_cnt_r;
        next_last_ptr_s = last_ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    next_grant_s = arb_grant_s;
                    if (WAIT_EFF > 0) begin
                        next_state_s    = ST_WAIT;
                        next_wait_cnt_s = WAIT_LOAD;
                    end else begin
                        next_state_s    = ST_HOLD;
                    end
                end else begin
                    next_grant_s = {NUM_CH{1'b0}};
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == {WAIT_CNT_W{1'b0}}) begin
                    next_state_s = ST_HOLD;
                end else begin
                    next_wait_cnt_s = wait_cnt_r - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_HOLD: begin
                if (!hold_busy_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            ST_DONE: begin
                // req is deliberately not looked at here
                next_state_s    = ST_IDLE;
                next_grant_s    = {NUM_CH{1'b0}};
                next_wait_cnt_s = {WAIT_CNT_W{1'b0}};
                next_last_ptr_s = grant_idx_s;
            end
            default: begin
                next_state_s    = ST_IDLE;
                next_grant_s    = {NUM_CH{1'b0}};
                next_wait_cnt_s = {WAIT_CNT_W{1'b0}};
            end
        endcase
    end

    // State registers; reset points the round-robin search at channel 0 next
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            grant_r    <= {NUM_CH{1'b0}};
            wait_cnt_r <= {WAIT_CNT_W{1'b0}};
            last_ptr_r <= PTR_W'(NUM_CH - 1);
        end else begin
            state_r    <= next_state_s;
            grant_r    <= next_grant_s;
            wait_cnt_r <= next_wait_cnt_s;
            last_ptr_r <= next_last_ptr_s;
        end
    end

    // Clock enable: run in DONE or when idle with nothing requested, never in reset
    always_comb begin
        if (rst) begin
            proc_ce = 1'b0;
        end else if (state_r == ST_DONE) begin
            proc_ce = 1'b1;
        end else if ((state_r == ST_IDLE) && (req == {NUM_CH{1'b0}})) begin
            proc_ce = 1'b1;
        end else begin
            proc_ce = 1'b0;
        end
    end

    assign grant = grant_r;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Saturating stall-cycle counter; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (perf_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!proc_ce && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    // Counter width is only meaningful when the performance counter is built
    logic [CNT_W-1:0] unused_cnt_w_s;
    assign unused_cnt_w_s = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_proc_stall_ctrl.sv
// Bench for proc_stall_ctrl: two instances (WAIT_CYCLES=2 and WAIT_CYCLES=0),
// directed stimulus, and per-instance monitors that score every DONE cycle
// (grant value and length of the preceding proc_ce=0 run) against a queue.
module tb_proc_stall_ctrl;
    import proc_stall_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_a, busy_a, grant_a;
    logic [1:0] req_b, busy_b, grant_b;
    logic       ce_a, ce_b;
`ifdef STALL_PERF_CNT_EN
    logic        perf_clr_a, perf_clr_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
`endif

    always #5 clk = ~clk;

    proc_stall_ctrl #(.NUM_CH(2), .WAIT_CYCLES(2), .CNT_W(16)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .req     (req_a),
        .busy    (busy_a),
        .grant   (grant_a),
        .proc_ce (ce_a)
`ifdef STALL_PERF_CNT_EN
        ,
        .perf_clr  (perf_clr_a),
        .stall_cnt (cnt_a)
`endif
    );

    proc_stall_ctrl #(.NUM_CH(2), .WAIT_CYCLES(0), .CNT_W(4)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .req     (req_b),
        .busy    (busy_b),
        .grant   (grant_b),
        .proc_ce (ce_b)
`ifdef STALL_PERF_CNT_EN
        ,
        .perf_clr  (perf_clr_b),
        .stall_cnt (cnt_b)
`endif
    );

    typedef struct {
        logic [1:0] grant;
        int         stall;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   run_a    = 0;
    int   run_b    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor A: count stall cycles, score each DONE cycle
    always @(negedge clk) begin
        if (rst) begin
            run_a = 0;
        end else if (!ce_a) begin
            run_a++;
        end else if (grant_a != 2'b00) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_done", int'(grant_a), 0);
            end else begin
                e_a = q_a.pop_front();
                check("a_grant", int'(grant_a), int'(e_a.grant));
                check("a_stall_len", run_a, e_a.stall);
            end
            run_a = 0;
        end else begin
            run_a = 0;
        end
    end

    // Monitor B: same scoring for the zero-wait instance
    always @(negedge clk) begin
        if (rst) begin
            run_b = 0;
        end else if (!ce_b) begin
            run_b++;
        end else if (grant_b != 2'b00) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_done", int'(grant_b), 0);
            end else begin
                e_b = q_b.pop_front();
                check("b_grant", int'(grant_b), int'(e_b.grant));
                check("b_stall_len", run_b, e_b.stall);
            end
            run_b = 0;
        end else begin
            run_b = 0;
        end
    end

    initial begin
        rst = 1'b1; req_a = 2'b00; busy_a = 2'b00; req_b = 2'b00; busy_b = 2'b00;
`ifdef STALL_PERF_CNT_EN
        perf_clr_a = 1'b0; perf_clr_b = 1'b0;
`endif
        // Reset: proc_ce low even with requests present, grant cleared
        #2 req_a = 2'b11;
        #1;
        check("rst_ce_with_req", int'(ce_a), 0);
        check("rst_grant", int'(grant_a), 0);
`ifdef STALL_PERF_CNT_EN
        check("rst_cnt_a", int'(cnt_a), 0);
`endif
        req_a = 2'b00;
        cyc(2);
        rst = 1'b0;
        #1;
        check("idle_ce_a", int'(ce_a), 1);
        check("idle_ce_b", int'(ce_b), 1);

        // Single access, two wait states, no busy: 4 stall cycles
        q_a.push_back('{2'b01, 4});
        req_a = 2'b01;
        cyc(4);
        req_a = 2'b00;
        cyc(2);
        check("idle_after_done_ce", int'(ce_a), 1);
        check("idle_after_done_grant", int'(grant_a), 0);

        // Both channels requesting from reset: 01, 10, 01
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        q_a.push_back('{2'b01, 4});
        q_a.push_back('{2'b10, 4});
        q_a.push_back('{2'b01, 4});
        req_a = 2'b11;
        cyc(14);
        req_a = 2'b00;
        cyc(2);

        // Channel 1 busy ignored; channel 0 drops req in HOLD and still completes
        q_a.push_back('{2'b01, 6});
        req_a = 2'b01; busy_a = 2'b11;
        cyc(5);
        busy_a = 2'b10; req_a = 2'b00;
        cyc(2);
        busy_a = 2'b00;
        cyc(1);

        // Reset mid-WAIT takes effect without a clock edge
        req_a = 2'b10;
        cyc(1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_grant", int'(grant_a), 0);
        check("rst_mid_state", int'(dut_a.state_r), int'(ST_IDLE));
        check("rst_mid_ce", int'(ce_a), 0);
        req_a = 2'b00;
        cyc(1);
        rst = 1'b0;
        #1;
        check("post_rst_ce", int'(ce_a), 1);
        q_a.push_back('{2'b01, 4});
        req_a = 2'b11;
        cyc(4);
        req_a = 2'b00;
        cyc(2);

        // Zero-wait instance: long stall (counter saturation and clear)
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
`ifdef STALL_PERF_CNT_EN
        check("cnt_b_after_rst", int'(cnt_b), 0);
`endif
        q_b.push_back('{2'b01, 22});
        req_b = 2'b01; busy_b = 2'b01;
        cyc(20);
`ifdef STALL_PERF_CNT_EN
        check("cnt_b_saturated", int'(cnt_b), 15);
        perf_clr_b = 1'b1;
`endif
        cyc(1);
`ifdef STALL_PERF_CNT_EN
        check("cnt_b_cleared", int'(cnt_b), 0);
        perf_clr_b = 1'b0;
`endif
        busy_b = 2'b00;
        cyc(1);
`ifdef STALL_PERF_CNT_EN
        check("cnt_b_after_clr", int'(cnt_b), 1);
`endif
        req_b = 2'b00;
        cyc(2);

        // Zero wait, busy[0] holds HOLD for 5 cycles: stall of 6
        q_b.push_back('{2'b01, 6});
        req_b = 2'b01; busy_b = 2'b01;
        cyc(5);
        busy_b = 2'b00;
        cyc(1);
        req_b = 2'b00;
        cyc(2);

        // Both request after channel 0 was last served: channel 1 wins, stall of 2
        q_b.push_back('{2'b10, 2});
        req_b = 2'b11;
        cyc(2);
        req_b = 2'b00;
        cyc(3);

        check("a_all_done", q_a.size(), 0);
        check("b_all_done", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/proc_stall_ctrl.md
PROC_STALL_CTRL -- requirements
Module: proc_stall_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of memory channels that can stall the processor (1..8).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the fixed wait states per granted access (0..15).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the performance counter width.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with the ports below.
- clk  in  1  single system clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-high reset.
- req  in  NUM_CH  per-channel access request, level, held by the source until its DONE cycle.
- busy  in  NUM_CH  per-channel memory-busy level, same meaning as a memory clock-stall flag.
- grant  out  NUM_CH  one-hot registered grant; all zero when no channel is granted.
- proc_ce  out  1  processor clock enable; this replaces clock gating.
- perf_clr  in  1  synchronous clear of stall_cnt (present only with STALL_PERF_CNT_EN).
- stall_cnt  out  CNT_W  stall-cycle count (present only with STALL_PERF_CNT_EN).

Function
REQ-005 The FSM SHALL have the states IDLE, WAIT, HOLD and DONE.
REQ-006 proc_ce SHALL be combinational: 1 in DONE, 1 in IDLE with req==0, and 0 otherwise.
REQ-007 From IDLE with any req bit set, the FSM SHALL register grant to the round-robin winner and go to WAIT if WAIT_CYCLES>0, otherwise to HOLD.
REQ-008 Round-robin SHALL search upward from the index after the last granted channel, wrapping at NUM_CH-1 to 0; after reset the search SHALL start at index 0.
REQ-009 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a down-counter, and then go to HOLD.
REQ-010 HOLD SHALL last at least one cycle and SHALL go to DONE on the first cycle that busy of the granted channel is 0.
REQ-011 DONE SHALL last exactly one cycle, clear grant, update the last-granted pointer, and return to IDLE.
REQ-012 req SHALL be ignored in DONE.
REQ-013 Simultaneous requests SHALL result in exactly one grant; the losing channels SHALL be served in later transactions in round-robin order.
REQ-014 busy on non-granted channels SHALL be ignored.
REQ-015 A granted channel that drops req before DONE SHALL still complete the transaction; there SHALL be no abort.
REQ-016 Stall latency SHALL be 1 (IDLE detect) + WAIT_CYCLES + the number of HOLD cycles, with proc_ce=0 throughout, followed by one proc_ce=1 cycle.
REQ-017 NUM_CH=1 SHALL degenerate to a fixed grant of bit 0.

Reset
REQ-018 Asserting rst at any time, including mid-transaction, SHALL immediately set: state IDLE, grant 0, wait counter 0, round-robin pointer to the last channel so the next search starts at 0, and stall_cnt 0.
REQ-019 While rst is high, proc_ce SHALL be 0 regardless of req.
REQ-020 After rst is released, proc_ce SHALL follow REQ-006.

Configuration
REQ-021 With macro STALL_PERF_CNT_EN defined:
- stall_cnt SHALL increment on every cycle that proc_ce==0 and rst==0.
- stall_cnt SHALL saturate at all ones.
- perf_clr SHALL zero it, with priority over increment.
REQ-022 Without STALL_PERF_CNT_EN, the perf_clr and stall_cnt ports and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-023 Shared package proc_stall_pkg SHALL hold the FSM state encoding (2-bit, IDLE=0, WAIT=1, HOLD=2, DONE=3) and the WAIT_CYCLES maximum constant.
REQ-024 The round-robin selection SHALL be a sub-module rr_arbiter with inputs req and last-grant pointer, and a one-hot output; it SHALL be purely combinational.

Verification
REQ-025 WAIT_CYCLES=2, req=01 for one transaction, busy=00 -> proc_ce=0 for 4 cycles, proc_ce=1 in DONE, grant=01 for cycles 1-4.
REQ-026 req=11 held from reset -> grants issued in the order 01, 10, 01, each separated by one DONE cycle.
REQ-027 WAIT_CYCLES=0, busy[0] high 5 cycles after grant -> HOLD lasts 5 cycles, then DONE, total stall 6 cycles.
REQ-028 rst asserted during WAIT -> grant=0 and state=IDLE without waiting for a clock edge; the next request grants channel 0.
REQ-029 STALL_PERF_CNT_EN, CNT_W=4, continuous stall for 20 cycles -> stall_cnt saturates at 15; perf_clr together with a stall cycle -> 0.
REQ-030 busy[1]=1 while channel 0 is granted -> channel 1's busy is ignored and channel 0 completes on busy[0]=0.
